// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memory responder: FSM states, address decode
// results, default MMIO addresses and the address decode helper.
package mem_bus_pkg;

    localparam int          STRB_W         = 4;
    localparam logic [31:0] DEF_LED_ADDR   = 32'h0000_0034;
    localparam logic [31:0] DEF_TIMER_ADDR = 32'h0000_0038;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    typedef enum logic [1:0] {DEC_RAM, DEC_LED, DEC_TIMER, DEC_ERR} dec_t;

    // Precedence: misalignment, LED, timer (when built in), in-range RAM, else error.
    function automatic dec_t decode_addr(input logic [31:0] addr,
                                         input logic [31:0] led_addr,
                                         input logic [31:0] timer_addr,
                                         input logic        timer_en,
                                         input int unsigned depth_words);
        dec_t res;
        if (addr[1:0] != 2'b00) begin
            res = DEC_ERR;
        end else if (addr == led_addr) begin
            res = DEC_LED;
        end else if (timer_en && (addr == timer_addr)) begin
            res = DEC_TIMER;
        end else if ({2'b00, addr[31:2]} < depth_words) begin
            res = DEC_RAM;
        end else begin
            res = DEC_ERR;
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between the core (master) and the memory responder (slave).
interface mem_responder_if;
    import mem_bus_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic [STRB_W-1:0] req_wstrb;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_wstrb,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_wstrb,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/mem_responder_ram.sv
// Single-port synchronous RAM, DEPTH_WORDS x 32, per-byte write enables.
// Read data appears one edge after en; contents are never reset.
module mem_responder_ram #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Bus target: RAM plus LED register, optional cycle timer under MEM_RESPONDER_TIMER_EN.
// Response WAIT_CYCLES+1 cycles after accept; req_ready low from accept until response ends.
module mem_responder
    import mem_bus_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] LED_ADDR    = DEF_LED_ADDR,
    parameter logic [31:0] TIMER_ADDR  = DEF_TIMER_ADDR
) (
    input  logic            clk,
    input  logic            reset,
    mem_responder_if.slave  bus,
    output logic [31:0]     toggle_value
);

    localparam int unsigned AW        = $clog2(DEPTH_WORDS);
    localparam logic [2:0]  WAIT_LOAD = (WAIT_CYCLES == 0) ? 3'd0 : 3'(WAIT_CYCLES - 1);
`ifdef MEM_RESPONDER_TIMER_EN
    localparam logic        TIMER_EN  = 1'b1;
`else
    localparam logic        TIMER_EN  = 1'b0;
`endif

    state_t            state_q, state_d;
    logic [2:0]        wait_cnt_q, wait_cnt_d;
    logic              write_q, write_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    dec_t              dec_q, dec_d;
    logic [31:0]       snap_q, snap_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              rsp_ram_q, rsp_ram_d;
    logic [31:0]       toggle_q, toggle_d;
    logic [31:0]       timer_now;

    dec_t              dec_in, cur_dec;
    logic              cur_write;
    logic [31:0]       cur_addr, cur_snap;
    logic              enter_resp;

    logic              ram_en;
    logic [3:0]        ram_we;
    logic [AW-1:0]     ram_addr;
    logic [31:0]       ram_rdata;

`ifdef MEM_RESPONDER_TIMER_EN
    logic [31:0] timer_q, timer_d;

    always_comb timer_d = timer_q + 32'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) timer_q <= '0;
        else       timer_q <= timer_d;
    end

    assign timer_now = timer_q;
`else
    assign timer_now = '0;
`endif

    assign dec_in = decode_addr(bus.req_addr, LED_ADDR, TIMER_ADDR, TIMER_EN, DEPTH_WORDS);

    // With zero wait states RESP is entered on the accept edge itself, so the
    // response is built from the live request rather than the latched copy.
    always_comb begin
        cur_write = (state_q == IDLE) ? bus.req_write : write_q;
        cur_addr  = (state_q == IDLE) ? bus.req_addr  : addr_q;
        cur_dec   = (state_q == IDLE) ? dec_in        : dec_q;
        cur_snap  = (state_q == IDLE) ? timer_now     : snap_q;
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        dec_d       = dec_q;
        snap_d      = snap_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        rsp_ram_d   = rsp_ram_q;
        toggle_d    = toggle_q;
        ram_en      = 1'b0;
        ram_we      = 4'b0000;
        ram_addr    = addr_q[AW+1:2];
        enter_resp  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    write_d = bus.req_write;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    wstrb_d = bus.req_wstrb;
                    dec_d   = dec_in;
                    snap_d  = timer_now;
                    if (WAIT_CYCLES == 0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d    = WAIT;
                        wait_cnt_d = WAIT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (wait_cnt_q == 3'd0) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q - 3'd1;
                end
            end
            RESP: begin
                state_d     = IDLE;
                rsp_rdata_d = '0;
                rsp_err_d   = 1'b0;
                rsp_ram_d   = 1'b0;
                if (write_q && (dec_q == DEC_RAM)) begin
                    ram_en = 1'b1;
                    ram_we = wstrb_q;
                end
                if (write_q && (dec_q == DEC_LED)) begin
                    for (int i = 0; i < STRB_W; i++) begin
                        if (wstrb_q[i]) toggle_d[8*i +: 8] = wdata_q[8*i +: 8];
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (enter_resp) begin
            rsp_err_d   = (cur_dec == DEC_ERR);
            rsp_ram_d   = (cur_dec == DEC_RAM) && !cur_write;
            rsp_rdata_d = '0;
            if (!cur_write && (cur_dec == DEC_LED))   rsp_rdata_d = toggle_q;
            if (!cur_write && (cur_dec == DEC_TIMER)) rsp_rdata_d = cur_snap;
            if ((cur_dec == DEC_RAM) && !cur_write) begin
                ram_en   = 1'b1;
                ram_addr = cur_addr[AW+1:2];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            wait_cnt_q  <= '0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            dec_q       <= DEC_ERR;
            snap_q      <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_ram_q   <= 1'b0;
            toggle_q    <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            dec_q       <= dec_d;
            snap_q      <= snap_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            rsp_ram_q   <= rsp_ram_d;
            toggle_q    <= toggle_d;
        end
    end

    mem_responder_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = rsp_ram_q ? ram_rdata : rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign toggle_value  = toggle_q;

endmodule
